// File: rtl/ddr_serialiser_pkg.sv
// ddr_serialiser_pkg: shared DDR pair width and the clamped-clog2 sizing macro
`ifndef DDR_CLOG2_MIN1
`define DDR_CLOG2_MIN1(x) (($clog2(x) > 1) ? $clog2(x) : 1)
`endif
package ddr_serialiser_pkg;
  localparam int DDR_PAIR_W = 2;
endpackage

// File: rtl/ddr_serialiser_word_hold_buf.sv
// word_hold_buf: single-entry W-bit holding register with push/pop handshake
module word_hold_buf #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= pop ? 1'b0 : (push ? 1'b1 : valid);
      data  <= push ? push_data : data;
    end
endmodule

// File: rtl/ddr_serialiser.sv
// ddr_serialiser: parallel word to DDR pad pairs, LSB first, with one-word hold buffer.
// Optional sticky gap flag under `DDR_SERIALISER_UNDERRUN_EN.
module ddr_serialiser
  import ddr_serialiser_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         d_rise,
  output logic         d_fall,
  output logic         e,
  output logic         busy,
  output logic         underrun,
  input  logic         underrun_clr
);
  localparam int CW = `DDR_CLOG2_MIN1(W/2);
  logic          shift_valid;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sr;
  logic          hold_valid;
  logic [W-1:0]  hold_data;
  logic          last, load_en, xfer, direct;
  assign last     = shift_valid & (cnt == CW'(W/2-1));
  assign load_en  = ~shift_valid | last;
  assign in_ready = ~hold_valid;
  assign xfer     = in_valid & in_ready;
  // Hold is only filled when the shifter cannot take the word this edge.
  assign direct   = load_en & ~hold_valid & xfer;
  word_hold_buf #(.W(W)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .push      (xfer & ~direct),
    .push_data (in_data),
    .pop       (load_en & hold_valid),
    .valid     (hold_valid),
    .data      (hold_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shift_valid <= 1'b0;
      cnt         <= '0;
      sr          <= '0;
    end else if (load_en) begin
      shift_valid <= hold_valid | xfer;
      cnt         <= '0;
      sr          <= hold_valid ? hold_data : (xfer ? in_data : '0);
    end else begin
      sr  <= sr >> DDR_PAIR_W;
      cnt <= cnt + 1'b1;
    end
  assign d_rise = sr[0];
  assign d_fall = sr[1];
  assign e      = shift_valid;
  assign busy   = shift_valid | hold_valid;
`ifdef DDR_SERIALISER_UNDERRUN_EN
  logic ur_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ur_q <= 1'b0;
    else if (last & ~hold_valid & ~xfer) ur_q <= 1'b1;
    else if (underrun_clr) ur_q <= 1'b0;
  assign underrun = ur_q;
`else
  logic unused_clr;
  assign unused_clr = underrun_clr;
  assign underrun   = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_serialiser.sv
// tb_ddr_serialiser: queue-based model check of ddr_serialiser (W=10) plus a W=2 instance
module tb_ddr_serialiser;
  localparam int W = 10;
`ifdef DDR_SERIALISER_UNDERRUN_EN
  localparam logic UR_EN = 1'b1;
`else
  localparam logic UR_EN = 1'b0;
`endif
  logic clk, rst, in_valid, in_ready, d_rise, d_fall, e, busy, underrun, underrun_clr;
  logic [W-1:0] in_data;
  logic in_valid2, in_ready2, d_rise2, d_fall2, e2, busy2, underrun2;
  logic [1:0] in_data2;
  int vectors = 0, miscompares = 0;
  logic chk_en = 1'b0;

  ddr_serialiser #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .d_rise(d_rise), .d_fall(d_fall), .e(e), .busy(busy), .underrun(underrun),
    .underrun_clr(underrun_clr));

  ddr_serialiser #(.W(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .d_rise(d_rise2), .d_fall(d_fall2), .e(e2), .busy(busy2), .underrun(underrun2),
    .underrun_clr(1'b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of accepted words; head word is on the pads at pair index pos.
  logic [W-1:0] q[$];
  int pos = 0;
  logic m_ur = 1'b0;
  always @(posedge clk or posedge rst) begin
    logic acc, popped;
    if (rst) begin
      q.delete();
      pos  = 0;
      m_ur = 1'b0;
    end else begin
      acc    = in_valid && (q.size() < 2);
      popped = 1'b0;
      if (q.size() > 0) begin
        pos++;
        if (pos == W/2) begin
          void'(q.pop_front());
          pos    = 0;
          popped = 1'b1;
        end
      end
      if (acc) q.push_back(in_data);
      m_ur = UR_EN & ((popped && q.size() == 0) ? 1'b1 : (underrun_clr ? 1'b0 : m_ur));
    end
  end

  int run = 0, last_run = 0, zrun = 0, last_gap = 0;
  logic seen_e = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] head;
    logic [1:0] pair;
    if (chk_en && !rst) begin
      head = (q.size() > 0) ? q[0] : '0;
      pair = (q.size() > 0) ? head[2*pos +: 2] : 2'b00;
      chk("e", e, q.size() > 0);
      chk("pair", {d_fall, d_rise}, pair);
      chk("in_ready", in_ready, q.size() < 2);
      chk("busy", busy, q.size() > 0);
      chk("underrun", underrun, m_ur);
      if (e) begin
        run++;
        if (seen_e && zrun > 0) last_gap = zrun;
        zrun   = 0;
        seen_e = 1'b1;
      end else begin
        if (run > 0) last_run = run;
        run = 0;
        zrun++;
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    logic ok;
    int budget = 50;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      ok = in_ready;
      @(posedge clk);
      #2;
      budget--;
    end while (!ok && budget > 0);
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    in_valid = 1'b0;
  endtask

  logic [1:0] single_exp [5] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b11};

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; underrun_clr = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0;
    #3 rst = 1'b1;
    #1;
    chk("rst_e", e, 0);
    chk("rst_pair", {d_fall, d_rise}, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_e2", e2, 0);
    @(posedge clk); #3 rst = 1'b0;
    chk_en = 1'b1;
    // single word with idle shifter
    push_word(10'b11_10_01_00_11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("single_pair", {d_fall, d_rise}, single_exp[i]);
      chk("single_e", e, 1);
    end
    @(negedge clk);
    chk("single_end_e", e, 0);
    chk("single_underrun", underrun, UR_EN);
    @(posedge clk); #2 underrun_clr = 1'b1;
    @(posedge clk); #2 underrun_clr = 1'b0;
    // back-to-back stream
    push_word(10'h155);
    push_word(10'h2AA);
    push_word(10'h3FF);
    repeat (20) @(negedge clk);
    chk("b2b_run", last_run, 15);
    // late producer: second word one cycle after the first word's last edge
    seen_e = 1'b0; zrun = 0; last_gap = 0;
    push_word(10'h0F3);
    repeat (5) @(posedge clk);
    #2;
    push_word(10'h1A5);
    repeat (8) @(negedge clk);
    chk("late_gap", last_gap, 1);
    chk("late_underrun", underrun, UR_EN);
    @(posedge clk); #2 underrun_clr = 1'b1;
    @(posedge clk); #2 underrun_clr = 1'b0;
    @(negedge clk);
    chk("clr_underrun", underrun, 0);
    // reset mid-word with hold full
    push_word(10'h3FF);
    push_word(10'h155);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("mid_rst_e", e, 0);
    chk("mid_rst_pair", {d_fall, d_rise}, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    #3 rst = 1'b0;
    push_word(10'h2AA);
    @(negedge clk);
    chk("post_rst_pair0", {d_fall, d_rise}, 2'b10);
    chk("post_rst_e", e, 1);
    repeat (8) @(negedge clk);
    // W=2: one word per clock, alternating data
    for (int i = 0; i < 8; i++) begin
      in_valid2 = 1'b1;
      in_data2  = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("w2_ready", in_ready2, 1);
      @(posedge clk);
      #1;
      chk("w2_rise", d_rise2, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("w2_e", e2, 1);
    end
    in_valid2 = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
